// File: rtl/roll_sequencer_pkg.sv
// roll_sequencer_pkg: shared state encoding and divider-array sizing for the roll sequencer
package roll_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DECEL = 2'd2, DONE = 2'd3} state_t;
  localparam int NUM_SPEEDS_DEF = 7;
endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect: two-flop synchroniser with a one-cycle rising-edge pulse per bit
module tick_edge_detect #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tick_in,
  output logic [W-1:0] rise
);
  logic [W-1:0] t1, t2;
  always_ff @(posedge clk) begin
    if (rst) begin
      t1 <= '0;
      t2 <= '0;
    end else begin
      t1 <= tick_in;
      t2 <= t1;
    end
  end
  assign rise = t1 & ~t2;
endmodule

// File: rtl/roll_sequencer.sv
// roll_sequencer: rolls an item index at the fastest tick, decelerates through slower ticks on stop, latches the pick
module roll_sequencer
  import roll_sequencer_pkg::*;
#(
  parameter int NUM_ITEMS       = 8,
  parameter int IDX_W           = 3,
  parameter int NUM_SPEEDS      = NUM_SPEEDS_DEF,
  parameter int STEPS_PER_SPEED = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [NUM_SPEEDS-1:0] tick_in,
  output logic [IDX_W-1:0]      cur_index,
  output logic [2:0]            speed,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      result
);
  localparam int SW = $clog2(STEPS_PER_SPEED) + 1;
  state_t state, state_n;
  logic [NUM_SPEEDS-1:0] rise;
  logic [SW-1:0] step_cnt, step_n;
  logic [IDX_W-1:0] idx_nx, idx_n, result_n;
  logic [2:0] speed_n;
  logic sel_rise, last_step, last_lvl, launch, dstep, adv, busy_n, done_n;
  tick_edge_detect #(.W(NUM_SPEEDS)) u_edge (
    .clk(clk),
    .rst(rst),
    .tick_in(tick_in),
    .rise(rise)
  );
  assign sel_rise  = rise[speed];
  assign last_step = step_cnt >= SW'(STEPS_PER_SPEED - 1);
  assign last_lvl  = speed >= 3'(NUM_SPEEDS - 1);
  assign launch    = (state == IDLE || state == DONE) && start;
  assign dstep     = state == DECEL && sel_rise;
  // a rise coinciding with stop is still a RUN advance, so DECEL counting starts afterwards
  assign adv       = sel_rise && (state == RUN || state == DECEL);
  assign idx_nx    = cur_index == IDX_W'(NUM_ITEMS - 1) ? '0 : cur_index + 1'b1;
  assign idx_n     = adv ? idx_nx : cur_index;
  assign speed_n   = launch ? 3'd0 : (dstep && last_step && !last_lvl) ? speed + 3'd1 : speed;
  assign step_n    = (launch || (state == RUN && stop)) ? '0 : dstep ? (last_step ? '0 : step_cnt + 1'b1) : step_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_index <= '0;
      speed     <= '0;
      step_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_n;
      cur_index <= idx_n;
      speed     <= speed_n;
      step_cnt  <= step_n;
      busy      <= busy_n;
      done      <= done_n;
      result    <= result_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? RUN : state;
      RUN:        state_n = stop ? DECEL : RUN;
      DECEL:      state_n = (sel_rise && last_step && last_lvl) ? DONE : DECEL;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    busy_n   = state_n == RUN || state_n == DECEL;
    done_n   = state_n == DONE;
    result_n = (state == DECEL && state_n == DONE) ? idx_nx : result;
  end
endmodule

// File: tb/tb_roll_sequencer.sv
// tb_roll_sequencer: table-driven and directed checks of roll_sequencer at 8 and 6 items
module tb_roll_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [6:0] tick_in = '0;
  logic [2:0] cur_index, speed, result, cur6, result6, speed6;
  logic busy, done, busy6, done6;
  int nerr = 0, nchk = 0;

  typedef struct {
    bit st;
    bit sp;
    int tk;
    int adv;
    int spd;
    bit bsy;
    bit dn;
    int res8;
    int res6;
  } vec_t;
  vec_t vecs[64];
  int nv = 0, adv = 0, r8 = 0, r6 = 0;

  always #5 clk = ~clk;

  roll_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick_in(tick_in),
    .cur_index(cur_index), .speed(speed), .busy(busy), .done(done), .result(result)
  );
  roll_sequencer #(.NUM_ITEMS(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick_in(tick_in),
    .cur_index(cur6), .speed(speed6), .busy(busy6), .done(done6), .result(result6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int b);
    tick_in[b] = 1'b1;
    step();
    step();
    tick_in[b] = 1'b0;
    step();
    step();
  endtask

  task automatic push(input bit st, input bit sp, input int tk, input int spd, input bit bsy, input bit dn);
    vecs[nv] = '{st, sp, tk, adv, spd, bsy, dn, r8, r6};
    nv++;
  endtask

  initial begin
    // reset with ticks toggling
    for (int i = 0; i < 3; i++) begin
      tick_in = ~tick_in;
      step();
    end
    chk("rst_idx", 32'(cur_index), 0);
    chk("rst_speed", 32'(speed), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    rst = 1'b0;
    tick_in = '0;
    step();
    step();
    tick(0);
    chk("idle_no_adv", 32'(cur_index), 0);
    chk("idle_busy", 32'(busy), 0);

    // table: roll 13 advances, stop at index 5, decelerate, restart from DONE
    push(1, 0, -1, 0, 1, 0);
    for (int k = 1; k <= 13; k++) begin
      adv++;
      push(0, 0, 0, 0, 1, 0);
    end
    push(0, 0, 3, 0, 1, 0);
    push(0, 1, -1, 0, 1, 0);
    for (int k = 0; k < 14; k++) begin
      adv++;
      if (k == 13) begin
        r8 = adv % 8;
        r6 = adv % 6;
      end
      push(0, 0, k / 2, (k == 13) ? 6 : (k + 1) / 2, k != 13, k == 13);
    end
    push(0, 0, 6, 6, 0, 1);
    push(0, 0, 0, 6, 0, 1);
    push(0, 1, -1, 6, 0, 1);
    push(1, 0, -1, 0, 1, 0);
    adv++;
    push(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < nv; i++) begin
      if (vecs[i].st || vecs[i].sp) begin
        start = vecs[i].st;
        stop = vecs[i].sp;
        step();
        start = 1'b0;
        stop = 1'b0;
      end
      if (vecs[i].tk >= 0) tick(vecs[i].tk);
      chk($sformatf("v%0d_idx", i), 32'(cur_index), vecs[i].adv % 8);
      chk($sformatf("v%0d_idx6", i), 32'(cur6), vecs[i].adv % 6);
      chk($sformatf("v%0d_speed", i), 32'(speed), vecs[i].spd);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_result", i), 32'(result), vecs[i].res8);
      chk($sformatf("v%0d_result6", i), 32'(result6), vecs[i].res6);
    end

    // start+stop together in IDLE, then stop coincident with a rise at index 6
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", 32'(busy), 1);
    for (int k = 0; k < 6; k++) tick(0);
    chk("ss_idx6", 32'(cur_index), 6);
    chk("ss_still_run", 32'(speed), 0);
    tick_in[0] = 1'b1;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("coin_idx", 32'(cur_index), 7);
    chk("coin_speed", 32'(speed), 0);
    tick_in[0] = 1'b0;
    step();
    step();
    for (int k = 0; k < 14; k++) begin
      tick(k / 2);
      if (k == 1) chk("coin_lvl1", 32'(speed), 1);
    end
    chk("coin_done", 32'(done), 1);
    chk("coin_busy", 32'(busy), 0);
    chk("coin_result", 32'(result), 5);
    chk("coin_idx_final", 32'(cur_index), 5);
    chk("coin_result6", 32'(result6), 3);

    // reset mid-deceleration at speed 4
    start = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 0; k < 8; k++) tick(k / 2);
    chk("mid_speed", 32'(speed), 4);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_idx", 32'(cur_index), 0);
    chk("mid_rst_speed", 32'(speed), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_result", 32'(result), 0);
    tick(0);
    chk("mid_rst_idle", 32'(cur_index), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
